// File: rtl/io_debounce_pkg.sv
// Shared constants and helpers for the io_debounce_sync input conditioning stage.
package io_debounce_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned DEBOUNCE_CYCLES_MIN = 1;
  localparam int unsigned DEBOUNCE_CYCLES_MAX = 255;

  typedef enum logic {
    BIT_IDLE,
    BIT_COUNTING
  } bit_state_t;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchronizer chain, debounce counter, clean level register and
// optional rise/fall strobes (IO_DEBOUNCE_STROBE_EN).
module debounce_bit
  import io_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q;
  logic                   accept;
  bit_state_t             state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (ena) begin
      if (sync == clean_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        accept = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) clean_q <= sync;
    end
  end

  // The count itself is the state; nonzero means a candidate level is pending.
  assign state = (cnt_q == '0) ? BIT_IDLE : BIT_COUNTING;
  assign busy  = (state == BIT_COUNTING);
  assign clean = clean_q;

`ifdef IO_DEBOUNCE_STROBE_EN
  logic rise_q, fall_q;

  // accept is already gated by ena, so strobes fall to 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & sync;
      fall_q <= accept & ~sync;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/io_debounce_sync.sv
// Per-pin synchronize/debounce stage for the dedicated inputs; strobe outputs are
// live only when IO_DEBOUNCE_STROBE_EN is defined, otherwise tied to 0.
module io_debounce_sync
  import io_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] busy
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("io_debounce_sync: SYNC_STAGES out of range 2..4");
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN || DEBOUNCE_CYCLES > DEBOUNCE_CYCLES_MAX) begin : g_bad_deb
    $error("io_debounce_sync: DEBOUNCE_CYCLES out of range 1..255");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("io_debounce_sync: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .raw  (raw_in[i]),
      .clean(clean_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_io_debounce_sync.sv
// Self-checking bench for io_debounce_sync: per-cycle compare against a run-length
// model plus hand-computed checkpoints. Honours IO_DEBOUNCE_STROBE_EN.
module tb_io_debounce_sync;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;
  localparam int unsigned D = 16;
`ifdef IO_DEBOUNCE_STROBE_EN
  localparam bit STROBE = 1'b1;
`else
  localparam bit STROBE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clean_out, rise_pulse, fall_pulse, busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  io_debounce_sync #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: raw delayed S edges, then a level is accepted after D consecutive
  // enabled edges on which the delayed input disagrees with the accepted level.
  logic [W-1:0] dly[$];
  logic [W-1:0] m_clean, m_rise, m_fall, m_busy, s;
  int           run[W];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly.delete();
      for (int k = 0; k < int'(S); k++) dly.push_back('0);
      m_clean = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < int'(W); i++) run[i] = 0;
    end else begin
      s = dly.pop_front();
      dly.push_back(raw_in);
      m_rise = '0; m_fall = '0;
      if (ena) begin
        for (int i = 0; i < int'(W); i++) begin
          if (s[i] == m_clean[i]) run[i] = 0;
          else begin
            run[i] = run[i] + 1;
            if (run[i] == int'(D)) begin
              m_clean[i] = s[i];
              run[i] = 0;
              if (STROBE) begin
                m_rise[i] = s[i];
                m_fall[i] = ~s[i];
              end
            end
          end
        end
      end
    end
    for (int i = 0; i < int'(W); i++) m_busy[i] = (run[i] != 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_clean", clean_out, m_clean);
      cmp("model_rise", rise_pulse, m_rise);
      cmp("model_fall", fall_pulse, m_fall);
      cmp("model_busy", busy, m_busy);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    step(2);
    rst_n = 1'b1;

    // Idle with all-zero inputs
    step(40);
    cmp("idle_clean", clean_out, 8'h00);
    cmp("idle_busy", busy, 8'h00);
    cmp("idle_rise", rise_pulse, 8'h00);
    cmp("idle_fall", fall_pulse, 8'h00);

    // Single-bit rise, full latency
    raw_in = 8'h01;
    step(2);  cmp("rise0_busy_e2", busy, 8'h00);
    step(1);  cmp("rise0_busy_e3", busy, 8'h01);
    step(14); cmp("rise0_busy_e17", busy, 8'h01);
              cmp("rise0_clean_e17", clean_out, 8'h00);
    step(1);  cmp("rise0_clean_e18", clean_out, 8'h01);
              cmp("rise0_strobe_e18", rise_pulse, STROBE ? 8'h01 : 8'h00);
              cmp("rise0_busy_e18", busy, 8'h00);
    step(1);  cmp("rise0_strobe_e19", rise_pulse, 8'h00);

    // Short pulse on bit 3 is rejected
    raw_in = 8'h09;
    step(10);
    raw_in = 8'h01;
    step(30);
    cmp("short_clean", clean_out, 8'h01);
    cmp("short_busy", busy, 8'h00);

    // Return to zero, then all bits rise with ena dropped 5 cycles from edge 8
    raw_in = 8'h00;
    step(40);
    cmp("clear_clean", clean_out, 8'h00);
    raw_in = 8'hFF;
    step(7);
    ena = 1'b0;
    step(5);
    cmp("ena_off_rise", rise_pulse, 8'h00);
    ena = 1'b1;
    step(10); cmp("ena_clean_e22", clean_out, 8'h00);
    step(1);  cmp("ena_clean_e23", clean_out, 8'hFF);
              cmp("ena_rise_e23", rise_pulse, STROBE ? 8'hFF : 8'h00);
    step(1);  cmp("ena_rise_e24", rise_pulse, 8'h00);

    // Bits 1 and 6 stable high, then fall together
    raw_in = 8'h42;
    step(40);
    cmp("pre_fall_clean", clean_out, 8'h42);
    raw_in = 8'h00;
    step(17); cmp("fall_e17", fall_pulse, 8'h00);
    step(1);  cmp("fall_e18", fall_pulse, STROBE ? 8'h42 : 8'h00);
              cmp("fall_clean_e18", clean_out, 8'h00);
    step(1);  cmp("fall_e19", fall_pulse, 8'h00);

    // Reset mid-count, then full latency after release
    raw_in = 8'h10;
    step(10);
    cmp("rst_pre_busy", busy, 8'h10);
    rst_n = 1'b0;
    #1;
    cmp("rst_clean", clean_out, 8'h00);
    cmp("rst_busy", busy, 8'h00);
    cmp("rst_rise", rise_pulse, 8'h00);
    step(2);
    rst_n = 1'b1;
    step(17); cmp("rst_clean_e17", clean_out, 8'h00);
    step(1);  cmp("rst_clean_e18", clean_out, 8'h10);
              cmp("rst_rise_e18", rise_pulse, STROBE ? 8'h10 : 8'h00);

    // Bounce mid-count restarts the count
    step(5);
    raw_in = 8'h00;
    step(8);
    raw_in = 8'h10;
    step(1);
    raw_in = 8'h00;
    step(17); cmp("bounce_clean_e17", clean_out, 8'h10);
    step(1);  cmp("bounce_clean_e18", clean_out, 8'h00);
              cmp("bounce_fall_e18", fall_pulse, STROBE ? 8'h10 : 8'h00);

    step(5);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
